// File: rtl/bc_pkg.sv
// bc_pkg: shared state/key codes, default sizing and LFSR taps for the Bulls-and-Cows controller.
package bc_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GEN    = 3'd1,
    S_ENTRY  = 3'd2,
    S_CHECK  = 3'd3,
    S_RESULT = 3'd4,
    S_WIN    = 3'd5,
    S_LOSE   = 3'd6
  } state_t;
  typedef enum logic [1:0] {
    KEY_DIGIT = 2'b00,
    KEY_ENTER = 2'b01,
    KEY_BACK  = 2'b10,
    KEY_RSVD  = 2'b11
  } key_t;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_MAX_TRIES = 10;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/bc_game_ctrl_if.sv
// bc_game_ctrl_if: key events in, game status out, between the PS/2 decoder and the display side.
interface bc_game_ctrl_if #(parameter int NUM_DIGITS = bc_pkg::DEF_NUM_DIGITS);
  logic key_valid;
  logic [1:0] key_type;
  logic [3:0] key_digit;
  logic [4*NUM_DIGITS-1:0] guess_flat;
  logic [4*NUM_DIGITS-1:0] secret_flat;
  logic [2:0] guess_len;
  logic [2:0] bulls;
  logic [2:0] cows;
  logic [3:0] tries;
  logic result_valid;
  logic err;
  logic win;
  logic lose;
  logic [2:0] state_o;
  modport slave (
    input key_valid, key_type, key_digit,
    output guess_flat, secret_flat, guess_len, bulls, cows, tries, result_valid, err, win, lose, state_o
  );
  modport master (
    output key_valid, key_type, key_digit,
    input guess_flat, secret_flat, guess_len, bulls, cows, tries, result_valid, err, win, lose, state_o
  );
endinterface

// File: rtl/bc_lfsr16.sv
// bc_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reloads SEED on reset.
module bc_lfsr16 import bc_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = lfsr_next(lfsr_q);
  always_ff @(posedge clk) lfsr_q <= rst ? SEED : lfsr_d;
  assign q = lfsr_q;
endmodule

// File: rtl/bc_game_ctrl.sv
// bc_game_ctrl: Bulls-and-Cows game FSM: secret generation, guess entry, one-pair-per-cycle scoring.
module bc_game_ctrl import bc_pkg::*; #(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int MAX_TRIES = DEF_MAX_TRIES,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic iCLK_50,
  input logic reset,
  bc_game_ctrl_if.slave bus
);
  localparam logic [2:0] ND = 3'(NUM_DIGITS);
  localparam logic [2:0] ND_M1 = 3'(NUM_DIGITS - 1);
  localparam logic [3:0] MT = 4'(MAX_TRIES);
  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;
  state_t state_q, state_d;
  digits_t guess_q, guess_d, secret_q, secret_d;
  logic [2:0] len_q, len_d, gen_cnt_q, gen_cnt_d, i_q, i_d, j_q, j_d;
  logic [2:0] tmp_b_q, tmp_b_d, tmp_c_q, tmp_c_d, bulls_q, bulls_d, cows_q, cows_d;
  logic [3:0] tries_q, tries_d;
  logic rv_q, rv_d, err_q, err_d, win_q, win_d, lose_q, lose_d;
  logic [15:0] lfsr;
  logic [3:0] cand, g_i, s_j;
  logic [2:0] b_n, c_n;
  logic dup_g, dup_s, hit, last_j, k_dig, k_ent, k_back;
  logic unused_lfsr;
  bc_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(iCLK_50), .rst(reset), .q(lfsr));
  assign unused_lfsr = ^lfsr[15:4];
  assign cand = lfsr[3:0];
  assign k_dig = bus.key_valid && bus.key_type == KEY_DIGIT;
  assign k_ent = bus.key_valid && bus.key_type == KEY_ENTER;
  assign k_back = bus.key_valid && bus.key_type == KEY_BACK;
  // duplicate detection and the (i,j) digit pair for the current scoring step
  always_comb begin
    dup_g = 1'b0;
    dup_s = 1'b0;
    g_i = '0;
    s_j = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k < int'(len_q) && guess_q[k] == bus.key_digit) dup_g = 1'b1;
      if (k < int'(gen_cnt_q) && secret_q[k] == cand) dup_s = 1'b1;
      if (k == int'(i_q)) g_i = guess_q[k];
      if (k == int'(j_q)) s_j = secret_q[k];
    end
    hit = g_i == s_j;
    b_n = tmp_b_q + {2'b00, hit && i_q == j_q};
    c_n = tmp_c_q + {2'b00, hit && i_q != j_q};
    last_j = j_q == ND_M1;
  end
  always_comb begin
    state_d = state_q;
    guess_d = guess_q;
    secret_d = secret_q;
    len_d = len_q;
    gen_cnt_d = gen_cnt_q;
    i_d = i_q;
    j_d = j_q;
    tmp_b_d = tmp_b_q;
    tmp_c_d = tmp_c_q;
    bulls_d = bulls_q;
    cows_d = cows_q;
    tries_d = tries_q;
    rv_d = 1'b0;
    err_d = 1'b0;
    win_d = win_q;
    lose_d = lose_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: if (k_ent) begin
        state_d = S_GEN;
        guess_d = '0;
        len_d = '0;
        gen_cnt_d = '0;
        bulls_d = '0;
        cows_d = '0;
        tries_d = '0;
        win_d = 1'b0;
        lose_d = 1'b0;
      end
      S_GEN: if (cand < 4'd10 && !dup_s) begin
        for (int k = 0; k < NUM_DIGITS; k++) if (k == int'(gen_cnt_q)) secret_d[k] = cand;
        gen_cnt_d = gen_cnt_q + 3'd1;
        state_d = gen_cnt_d == ND ? S_ENTRY : S_GEN;
      end
      S_ENTRY: begin
        if (k_dig) begin
          if (bus.key_digit > 4'd9 || dup_g || len_q == ND) err_d = 1'b1;
          else begin
            for (int k = 0; k < NUM_DIGITS; k++) if (k == int'(len_q)) guess_d[k] = bus.key_digit;
            len_d = len_q + 3'd1;
          end
        end else if (k_back && len_q != 3'd0) begin
          for (int k = 0; k < NUM_DIGITS; k++) if (k == int'(len_q) - 1) guess_d[k] = '0;
          len_d = len_q - 3'd1;
        end else if (k_ent) begin
          if (len_q == ND) begin
            state_d = S_CHECK;
            i_d = '0;
            j_d = '0;
            tmp_b_d = '0;
            tmp_c_d = '0;
          end else err_d = 1'b1;
        end
      end
      // the last pair's counts go straight into bulls/cows so they are valid during RESULT
      S_CHECK: begin
        tmp_b_d = b_n;
        tmp_c_d = c_n;
        j_d = last_j ? 3'd0 : j_q + 3'd1;
        i_d = last_j ? i_q + 3'd1 : i_q;
        if (last_j && i_q == ND_M1) begin
          state_d = S_RESULT;
          bulls_d = b_n;
          cows_d = c_n;
          tries_d = tries_q + 4'd1;
          rv_d = 1'b1;
        end
      end
      S_RESULT: begin
        win_d = bulls_q == ND;
        lose_d = bulls_q != ND && tries_q == MT;
        state_d = win_d ? S_WIN : lose_d ? S_LOSE : S_ENTRY;
        if (state_d == S_ENTRY) begin
          guess_d = '0;
          len_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge iCLK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      guess_q <= '0;
      secret_q <= '0;
      len_q <= '0;
      gen_cnt_q <= '0;
      i_q <= '0;
      j_q <= '0;
      tmp_b_q <= '0;
      tmp_c_q <= '0;
      bulls_q <= '0;
      cows_q <= '0;
      tries_q <= '0;
      rv_q <= 1'b0;
      err_q <= 1'b0;
      win_q <= 1'b0;
      lose_q <= 1'b0;
    end else begin
      state_q <= state_d;
      guess_q <= guess_d;
      secret_q <= secret_d;
      len_q <= len_d;
      gen_cnt_q <= gen_cnt_d;
      i_q <= i_d;
      j_q <= j_d;
      tmp_b_q <= tmp_b_d;
      tmp_c_q <= tmp_c_d;
      bulls_q <= bulls_d;
      cows_q <= cows_d;
      tries_q <= tries_d;
      rv_q <= rv_d;
      err_q <= err_d;
      win_q <= win_d;
      lose_q <= lose_d;
    end
  end
  assign bus.guess_flat = guess_q;
  assign bus.secret_flat = secret_q;
  assign bus.guess_len = len_q;
  assign bus.bulls = bulls_q;
  assign bus.cows = cows_q;
  assign bus.tries = tries_q;
  assign bus.result_valid = rv_q;
  assign bus.err = err_q;
  assign bus.win = win_q;
  assign bus.lose = lose_q;
  assign bus.state_o = state_q;
endmodule

// File: tb/tb_bc_game_ctrl.sv
// tb_bc_game_ctrl: randomized game sessions checked against a rule-level model of the controller.
module tb_bc_game_ctrl;
  import bc_pkg::*;
  localparam int ND = 4;
  localparam int MT = 10;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;
  bc_game_ctrl_if #(.NUM_DIGITS(ND)) bus ();
  bc_game_ctrl #(.NUM_DIGITS(ND), .MAX_TRIES(MT), .LFSR_SEED(SEED)) dut (
    .iCLK_50(clk),
    .reset(reset),
    .bus(bus)
  );
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] m_lfsr;
  int sec[ND];
  int gq[$];
  int m_tries;
  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  always @(posedge clk) m_lfsr <= reset ? SEED : nxt(m_lfsr);
  function automatic logic [31:0] sflat();
    logic [31:0] f = '0;
    for (int k = 0; k < ND; k++) f[4*k +: 4] = 4'(sec[k]);
    return f;
  endfunction
  function automatic logic [31:0] gflat();
    logic [31:0] f = '0;
    for (int k = 0; k < gq.size(); k++) f[4*k +: 4] = 4'(gq[k]);
    return f;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic key(input logic [1:0] t, input int d);
    bus.key_valid = 1'b1;
    bus.key_type = t;
    bus.key_digit = 4'(d);
    step();
    bus.key_valid = 1'b0;
  endtask
  task automatic rand_key_drive();
    bus.key_valid = 1'($urandom_range(0, 1));
    bus.key_type = 2'($urandom_range(0, 3));
    bus.key_digit = 4'($urandom_range(0, 15));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(bus.state_o), 0);
    chk({tag, "_guess"}, 32'(bus.guess_flat), 0);
    chk({tag, "_secret"}, 32'(bus.secret_flat), 0);
    chk({tag, "_len"}, 32'(bus.guess_len), 0);
    chk({tag, "_bc"}, {bus.bulls, bus.cows}, 0);
    chk({tag, "_tries"}, 32'(bus.tries), 0);
    chk({tag, "_flags"}, {bus.result_valid, bus.err, bus.win, bus.lose}, 0);
  endtask
  // secret comes from walking the LFSR sequence with the accept rule; keys during GEN must be ignored
  task automatic start_game();
    logic [15:0] l;
    int cnt, cyc, c;
    bit ok;
    key(KEY_ENTER, 0);
    chk("gen_enter_state", 32'(bus.state_o), S_GEN);
    chk("gen_enter_tries", 32'(bus.tries), 0);
    chk("gen_enter_winlose", {bus.win, bus.lose}, 0);
    l = m_lfsr;
    cnt = 0;
    cyc = 0;
    while (cnt < ND && cyc < 2000) begin
      c = int'(l[3:0]);
      ok = c < 10;
      for (int k = 0; k < cnt; k++) if (sec[k] == c) ok = 0;
      if (ok) begin
        sec[cnt] = c;
        cnt++;
      end
      l = nxt(l);
      cyc++;
    end
    repeat (cyc) begin
      chk("gen_state", 32'(bus.state_o), S_GEN);
      rand_key_drive();
      step();
      bus.key_valid = 1'b0;
      chk("gen_key_err", 32'(bus.err), 0);
      chk("gen_key_len", 32'(bus.guess_len), 0);
    end
    chk("entry_state", 32'(bus.state_o), S_ENTRY);
    chk("secret", 32'(bus.secret_flat), sflat());
    chk("entry_len", 32'(bus.guess_len), 0);
    chk("entry_tries", 32'(bus.tries), 0);
    gq.delete();
    m_tries = 0;
  endtask
  task automatic submit(input int g[ND]);
    int eb, ec, common, n, es;
    foreach (g[k]) begin
      key(KEY_DIGIT, g[k]);
      gq.push_back(g[k]);
      chk("type_err", 32'(bus.err), 0);
    end
    chk("typed_guess", 32'(bus.guess_flat), gflat());
    eb = 0;
    common = 0;
    for (int k = 0; k < ND; k++) begin
      if (g[k] == sec[k]) eb++;
      for (int m = 0; m < ND; m++) if (g[k] == sec[m]) common++;
    end
    ec = common - eb;
    key(KEY_ENTER, 0);
    n = 1;
    while (!bus.result_valid && n < 40) begin
      chk("check_state", 32'(bus.state_o), S_CHECK);
      chk("check_key_err", 32'(bus.err), 0);
      chk("check_guess", 32'(bus.guess_flat), gflat());
      rand_key_drive();
      step();
      bus.key_valid = 1'b0;
      n++;
    end
    chk("latency", n, ND * ND + 1);
    m_tries++;
    chk("bulls", 32'(bus.bulls), eb);
    chk("cows", 32'(bus.cows), ec);
    chk("tries", 32'(bus.tries), m_tries);
    chk("result_state", 32'(bus.state_o), S_RESULT);
    step();
    es = eb == ND ? S_WIN : m_tries == MT ? S_LOSE : S_ENTRY;
    if (es == S_ENTRY) gq.delete();
    chk("rv_pulse", 32'(bus.result_valid), 0);
    chk("post_state", 32'(bus.state_o), es);
    chk("post_win", 32'(bus.win), es == S_WIN);
    chk("post_lose", 32'(bus.lose), es == S_LOSE);
    chk("post_len", 32'(bus.guess_len), gq.size());
    chk("post_guess", 32'(bus.guess_flat), gflat());
  endtask
  task automatic rand_guess(output int g[ND], input bit diff);
    bit same, ok;
    do begin
      for (int k = 0; k < ND; k++) begin
        do begin
          g[k] = $urandom_range(0, 9);
          ok = 1;
          for (int m = 0; m < k; m++) if (g[m] == g[k]) ok = 0;
        end while (!ok);
      end
      same = 1;
      for (int k = 0; k < ND; k++) if (g[k] != sec[k]) same = 0;
    end while (diff && same);
  endtask
  initial begin
    int g[ND];
    int d, x;
    bit in_sec;
    bus.key_valid = 1'b0;
    bus.key_type = '0;
    bus.key_digit = '0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk_zero("reset");
    key(KEY_DIGIT, 3);
    chk("idle_digit_err", 32'(bus.err), 0);
    key(KEY_BACK, 0);
    chk("idle_back_err", 32'(bus.err), 0);
    chk("idle_state", 32'(bus.state_o), S_IDLE);
    chk("idle_len", 32'(bus.guess_len), 0);
    start_game();
    x = 0;
    for (int v = 9; v >= 0; v--) begin
      in_sec = 0;
      for (int k = 0; k < ND; k++) if (sec[k] == v) in_sec = 1;
      if (!in_sec) x = v;
    end
    g = '{sec[0], sec[2], x, sec[1]};
    submit(g);
    chk("b1c2_bulls", 32'(bus.bulls), 1);
    chk("b1c2_cows", 32'(bus.cows), 2);
    d = $urandom_range(0, 9);
    key(KEY_DIGIT, d);
    gq.push_back(d);
    chk("e_first_err", 32'(bus.err), 0);
    chk("e_first_len", 32'(bus.guess_len), 1);
    key(KEY_DIGIT, d);
    chk("e_dup_err", 32'(bus.err), 1);
    chk("e_dup_len", 32'(bus.guess_len), 1);
    chk("e_dup_guess", 32'(bus.guess_flat), gflat());
    key(KEY_ENTER, 0);
    chk("e_short_enter_err", 32'(bus.err), 1);
    chk("e_short_enter_state", 32'(bus.state_o), S_ENTRY);
    key(KEY_BACK, 0);
    void'(gq.pop_back());
    chk("e_back1_err", 32'(bus.err), 0);
    chk("e_back1_len", 32'(bus.guess_len), 0);
    chk("e_back1_guess", 32'(bus.guess_flat), 0);
    key(KEY_BACK, 0);
    chk("e_back2_err", 32'(bus.err), 0);
    chk("e_back2_len", 32'(bus.guess_len), 0);
    key(KEY_DIGIT, $urandom_range(10, 15));
    chk("e_big_err", 32'(bus.err), 1);
    chk("e_big_len", 32'(bus.guess_len), 0);
    key(KEY_RSVD, 2);
    chk("e_rsvd_err", 32'(bus.err), 0);
    chk("e_rsvd_len", 32'(bus.guess_len), 0);
    rand_guess(g, 0);
    foreach (g[k]) begin
      key(KEY_DIGIT, g[k]);
      gq.push_back(g[k]);
    end
    key(KEY_DIGIT, $urandom_range(0, 9));
    chk("e_full_err", 32'(bus.err), 1);
    chk("e_full_len", 32'(bus.guess_len), ND);
    chk("e_full_guess", 32'(bus.guess_flat), gflat());
    repeat (ND) begin
      key(KEY_BACK, 0);
      void'(gq.pop_back());
      chk("e_clear_guess", 32'(bus.guess_flat), gflat());
      chk("e_clear_len", 32'(bus.guess_len), gq.size());
    end
    submit(sec);
    chk("win_flag", 32'(bus.win), 1);
    chk("win_bulls", 32'(bus.bulls), ND);
    start_game();
    repeat (MT) begin
      rand_guess(g, 1);
      submit(g);
    end
    chk("lose_tries", 32'(bus.tries), MT);
    chk("lose_flag", 32'(bus.lose), 1);
    repeat (2) begin
      key(KEY_DIGIT, $urandom_range(0, 9));
      chk("lose_key_err", 32'(bus.err), 0);
      chk("lose_key_len", 32'(bus.guess_len), ND);
      chk("lose_key_guess", 32'(bus.guess_flat), gflat());
      chk("lose_key_state", 32'(bus.state_o), S_LOSE);
    end
    start_game();
    rand_guess(g, 0);
    foreach (g[k]) key(KEY_DIGIT, g[k]);
    key(KEY_ENTER, 0);
    repeat (5) step();
    chk("midcheck_state", 32'(bus.state_o), S_CHECK);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("midcheck_reset");
    gq.delete();
    start_game();
    rand_guess(g, 0);
    submit(g);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bc_game_ctrl.md
Name: bc_game_ctrl

Overview:
- Central game controller for the Bulls-and-Cows board. Generates a secret of NUM_DIGITS distinct decimal digits and collects guesses from the PS/2 key decoder.
- Scores each guess sequentially into bull and cow counts, tracks the attempt count and decides win or lose.
- Sits between the PS/2 scan-code decoder (upstream) and the VGA text renderer / LED driver (downstream).

Parameters:
- NUM_DIGITS, 4, digits in secret and guess (2..7)
- MAX_TRIES, 10, attempts before LOSE (1..15)
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- iCLK_50  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe, key event present
- key_type  in  2  00 digit, 01 enter, 10 backspace, 11 reserved (ignored)
- key_digit  in  4  digit value, meaningful when key_type=00
- guess_flat  out  4*NUM_DIGITS  current guess; digit k at [4k+3:4k], k=0 leftmost
- guess_len  out  3  digits entered so far (0..NUM_DIGITS)
- secret_flat  out  4*NUM_DIGITS  secret, same packing; top shows it only when lose=1
- bulls  out  3  bulls of last scored guess
- cows  out  3  cows of last scored guess
- tries  out  4  guesses scored in current game
- result_valid  out  1  one-cycle pulse, new bulls/cows/tries
- err  out  1  one-cycle pulse, key rejected
- win  out  1  level, game won
- lose  out  1  level, tries exhausted
- state_o  out  3  current FSM state code

Behaviour:
- Reset values: all outputs 0; state IDLE; LFSR = LFSR_SEED. Reset mid-operation aborts everything and returns to IDLE in the next cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state, so a human's key timing seeds randomness.
- States: IDLE=0, GEN=1, ENTRY=2, CHECK=3, RESULT=4, WIN=5, LOSE=6.
- IDLE / WIN / LOSE:
  - enter key -> GEN.
  - On leaving, clear guess, guess_len, bulls, cows, tries, win, lose, and the secret-accepted count.
  - All other keys are ignored with no err.
- GEN:
  - Each cycle, candidate = lfsr[3:0].
  - Accept if the candidate is <10 and not equal to any already-accepted secret digit; write it to position gen_cnt and increment gen_cnt.
  - When gen_cnt reaches NUM_DIGITS -> ENTRY.
  - Keys are ignored.
- ENTRY:
  - Digit key: append at position guess_len and increment guess_len. Instead pulse err, with no change, if the digit is >9, the digit is already in the guess, or guess_len==NUM_DIGITS.
  - Backspace: if guess_len>0, decrement guess_len and zero the vacated digit; if guess_len==0, ignore silently.
  - Enter: if guess_len==NUM_DIGITS -> CHECK; otherwise pulse err.
  - Reserved key type is ignored.
- CHECK:
  - Counters i,j step over all NUM_DIGITS*NUM_DIGITS pairs, j fastest, one pair per cycle.
  - If guess[i]==secret[j]: increment temp bull when i==j, otherwise increment temp cow.
  - Temp counters are cleared on CHECK entry. After the last pair -> RESULT.
  - Keys are ignored.
- RESULT (exactly one cycle):
  - bulls<=tmp_b, cows<=tmp_c, tries<=tries+1, result_valid=1.
  - Next state: WIN if tmp_b==NUM_DIGITS; else LOSE if tries+1==MAX_TRIES; else ENTRY with guess and guess_len cleared.
- Latency: enter accepted at cycle T -> result_valid at cycle T+NUM_DIGITS^2+1.
- bulls, cows and tries hold until the next RESULT or a new game. win/lose assert on entering WIN/LOSE and hold until the next game starts.
- Widths: bulls+cows<=NUM_DIGITS always. Counters are sized for the NUM_DIGITS=7 maximum, so no overflow.
- key_valid coincident with a state transition is evaluated against the current state only.

Decomposition:
- Package bc_pkg holds:
  - state enum / codes
  - key_type codes (KEY_DIGIT, KEY_ENTER, KEY_BACK)
  - default NUM_DIGITS and MAX_TRIES
  - LFSR tap mask
- Sub-module bc_lfsr16: free-running LFSR with seed parameter and 16-bit state output. Isolating it lets the bench force known secrets.

Test Plan:
- Reset, then enter; wait for ENTRY -> secret_flat holds 4 distinct digits, each <=9; guess_len=0; tries=0.
- With secret 1234: key 1,3,5,2 then enter -> result_valid exactly 17 cycles after the enter strobe, with bulls=1, cows=2, tries=1, state back to ENTRY, guess_len=0.
- Key 5, 5 -> second key gives an err pulse and guess_len=1. Enter with 1 digit -> err. Backspace twice -> guess_len=0, no err. Fifth digit on a full guess -> err.
- Guess equal to the secret -> bulls=4, cows=0, win=1, state WIN. Then enter -> GEN, win=0, tries=0.
- Ten wrong guesses -> after the 10th result_valid, tries=10, lose=1, state LOSE. Further digit keys give no err and no change.
- Assert reset mid-CHECK -> next cycle state IDLE and all outputs 0. Keys during GEN and CHECK never pulse err and never change the guess.
